// File: rtl/spi_master.sv
// Single-slave SPI master: one DATA_WIDTH-bit full-duplex word per accepted start, MSB first.
// state | meaning
// IDLE  | bus deselected, waiting for start
// LEAD  | cs_n low, sclk idle for one half period before the first edge
// XFER  | 2*DATA_WIDTH sclk edges, shift/sample according to CPHA
// TRAIL | cs_n low, sclk idle for one half period after the last edge
// GUARD | cs_n high and still busy before the next frame may begin
module spi_master #(
   parameter int CLK_FREQUENCE = 50_000_000,
   parameter int SPI_FREQUENCE = 5_000_000,
   parameter int DATA_WIDTH    = 8,
   parameter int CPOL          = 1,
   parameter int CPHA          = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  miso,
   output logic                  sclk,
   output logic                  cs_n,
   output logic                  mosi,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] data_out
);
   localparam int HALF = CLK_FREQUENCE / (2 * SPI_FREQUENCE);
   localparam int HCW  = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int ECW  = $clog2(2 * DATA_WIDTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEAD  = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_TRAIL = 3'd3;
   localparam logic [2:0] S_GUARD = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [HCW-1:0]        half_q, half_d;
   logic [ECW-1:0]        edge_q, edge_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
   logic                  sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  tick, lead_edge, last_edge;

   assign tick      = (half_q == HCW'(HALF - 1));
   assign lead_edge = ~edge_q[0];
   assign last_edge = (edge_q == ECW'(2 * DATA_WIDTH - 1));

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (state_q != S_IDLE) half_d = tick ? '0 : half_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            half_d = '0;
            edge_d = '0;
            sclk_d = 1'(CPOL);
            if (start) begin
               tx_d    = data_in;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_LEAD;
            end
         end
         S_LEAD: if (tick) state_d = S_XFER;
         S_XFER: if (tick) begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + 1'b1;
            if (CPHA == 0) begin
               if (lead_edge)       rx_d = {rx_q[DATA_WIDTH-2:0], miso};
               else if (!last_edge) tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
               if (!lead_edge)          rx_d = {rx_q[DATA_WIDTH-2:0], miso};
               else if (edge_q != '0)   tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (last_edge) begin
               edge_d  = '0;
               state_d = S_TRAIL;
            end
         end
         S_TRAIL: if (tick) begin
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            dout_d  = rx_q;
            // The following IDLE cycle completes the HALF-cycle deselect gap,
            // so GUARD itself only needs HALF-1 cycles.
            half_d  = HCW'(1);
            state_d = S_GUARD;
         end
         S_GUARD: if (tick) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      mosi_d = cs_n_d ? 1'b0 : tx_d[DATA_WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         half_q  <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         sclk_q  <= 1'(CPOL);
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sclk     = sclk_q;
   assign cs_n     = cs_n_q;
   assign mosi     = mosi_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign data_out = dout_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three configurations checked every cycle against a frame-timing model.
module tb_spi_master;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst_v, start_v, miso_v, sclk_v, cs_n_v, mosi_v, busy_v, done_v;
   logic [15:0] din_v [3];
   logic [15:0] dout_v [3];
   logic [15:0] slave_w [3];
   logic [7:0]  dout0, dout1;
   logic [15:0] dout2;

   int half_c [3] = '{5, 5, 2};
   int dw_c   [3] = '{8, 8, 16};
   int cpol_c [3] = '{1, 0, 1};
   int cpha_c [3] = '{1, 0, 0};

   spi_master u0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .data_in(din_v[0][7:0]), .miso(miso_v[0]),
      .sclk(sclk_v[0]), .cs_n(cs_n_v[0]), .mosi(mosi_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .data_out(dout0));
   spi_master #(.CPOL(0), .CPHA(0)) u1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .data_in(din_v[1][7:0]), .miso(miso_v[1]),
      .sclk(sclk_v[1]), .cs_n(cs_n_v[1]), .mosi(mosi_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .data_out(dout1));
   spi_master #(.CLK_FREQUENCE(40_000_000), .SPI_FREQUENCE(10_000_000), .DATA_WIDTH(16),
                .CPOL(1), .CPHA(0)) u2 (
      .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .data_in(din_v[2]), .miso(miso_v[2]),
      .sclk(sclk_v[2]), .cs_n(cs_n_v[2]), .mosi(mosi_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .data_out(dout2));

   assign dout_v[0] = {8'h00, dout0};
   assign dout_v[1] = {8'h00, dout1};
   assign dout_v[2] = dout2;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int cnt = 0;

   // model: a frame is described only by its accept time and the two words
   bit          act [3] = '{0, 0, 0};
   int          fa [3] = '{0, 0, 0};
   logic [15:0] tx_m [3];
   logic [15:0] sw_m [3];
   logic [15:0] exp_dout [3] = '{16'h0, 16'h0, 16'h0};
   int          kp, kn, nn, sh, ss, fl;
   logic        sclk_e, mosi_e, cs_e;

   task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, inst, cnt, got, exp);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         kp = cnt - fa[i];
         fl = half_c[i] * (2 * dw_c[i] + 2);
         if (rst_v[i]) begin
            act[i]      = 1'b0;
            exp_dout[i] = '0;
         end else if (act[i]) begin
            if (kp == fl) exp_dout[i] = sw_m[i];
            if (kp == fl + half_c[i] - 1) act[i] = 1'b0;
         end else if (start_v[i]) begin
            act[i]  = 1'b1;
            fa[i]   = cnt;
            tx_m[i] = din_v[i];
            sw_m[i] = slave_w[i];
         end
      end
      cnt++;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         fl = half_c[i] * (2 * dw_c[i] + 2);
         kn = cnt - fa[i];
         if (act[i] && kn <= fl) begin
            nn = (kn - 1) / half_c[i] - 1;
            if (nn < 0) nn = 0;
            if (nn > 2 * dw_c[i]) nn = 2 * dw_c[i];
            if (cpha_c[i] == 0) begin
               sh = nn / 2;
               if (sh > dw_c[i] - 1) sh = dw_c[i] - 1;
               ss = (nn + 1) / 2;
            end else begin
               sh = (nn + 1) / 2 - 1;
               if (sh < 0) sh = 0;
               ss = nn / 2;
            end
            cs_e   = 1'b0;
            sclk_e = cpol_c[i][0] ^ nn[0];
            mosi_e = tx_m[i][dw_c[i] - 1 - sh];
            miso_v[i] = (ss < dw_c[i]) ? sw_m[i][dw_c[i] - 1 - ss] : 1'b0;
         end else begin
            cs_e   = 1'b1;
            sclk_e = cpol_c[i][0];
            mosi_e = 1'b0;
            miso_v[i] = 1'b0;
         end
         if (chk_en) begin
            chk("sclk", i, sclk_v[i], sclk_e);
            chk("cs_n", i, cs_n_v[i], cs_e);
            chk("mosi", i, mosi_v[i], mosi_e);
            chk("busy", i, busy_v[i], act[i]);
            chk("done", i, done_v[i], act[i] && kn == fl + 1);
            chk("data_out", i, dout_v[i], exp_dout[i]);
         end
      end
   end

   task automatic run_frame(input int i, input logic [15:0] d, input logic [15:0] sw, input int bound,
                            input int probe_k, input int extra_at,
                            output int lat, output int cs_low, output int edges, output int ndone,
                            output logic [15:0] dcap, output logic pm, output logic ps);
      logic prev;
      lat = -1; cs_low = 0; edges = 0; ndone = 0; dcap = '0; pm = 1'b0; ps = 1'b0;
      din_v[i] = d; slave_w[i] = sw; start_v[i] = 1'b1;
      prev = sclk_v[i];
      for (int j = 1; j <= bound; j++) begin
         @(negedge clk);
         start_v[i] = (j == extra_at);
         din_v[i]   = (j == extra_at) ? 16'h000F : d;
         if (!cs_n_v[i]) cs_low++;
         if (sclk_v[i] !== prev) edges++;
         prev = sclk_v[i];
         if (done_v[i]) begin
            ndone++;
            if (lat < 0) begin
               lat  = j;
               dcap = dout_v[i];
            end
         end
         if (j == probe_k) begin
            pm = mosi_v[i];
            ps = sclk_v[i];
         end
      end
   endtask

   task automatic wait_done(input int i, input int lim, output int t);
      t = -1;
      for (int j = 0; j < lim; j++) begin
         @(negedge clk);
         if (done_v[i]) begin
            t = cnt;
            break;
         end
      end
      if (t < 0) chk("done_timeout", i, done_v[i], 1);
   endtask

   int lat, csl, edg, nd, hc, t1, t2, t3;
   logic [15:0] dcap;
   logic pm, ps;

   initial begin
      rst_v = 3'b111;
      start_v = 3'b000;
      for (int i = 0; i < 3; i++) begin
         din_v[i] = '0;
         slave_w[i] = '0;
      end
      repeat (3) @(negedge clk);
      rst_v = 3'b000;
      chk_en = 1'b1;
      chk("reset_cs_n", 0, cs_n_v, 3'b111);
      chk("reset_sclk", 0, sclk_v, 3'b101);

      // mode 3 loopback
      run_frame(0, 16'hA5, 16'h3C, 120, 0, -1, lat, csl, edg, nd, dcap, pm, ps);
      chk("m3_latency", 0, lat, 91);
      chk("m3_cs_low", 0, csl, 90);
      chk("m3_edges", 0, edg, 16);
      chk("m3_ndone", 0, nd, 1);
      chk("m3_data_out", 0, dcap, 16'h3C);

      // second start mid-frame is ignored
      run_frame(0, 16'hC6, 16'h5B, 120, 0, 20, lat, csl, edg, nd, dcap, pm, ps);
      chk("ign_ndone", 0, nd, 1);
      chk("ign_latency", 0, lat, 91);
      chk("ign_data_out", 0, dcap, 16'h5B);

      // start held: back-to-back frames
      din_v[0] = 16'h01; slave_w[0] = 16'h11; start_v[0] = 1'b1;
      wait_done(0, 200, t1);
      chk("held_dout1", 0, dout_v[0], 16'h11);
      din_v[0] = 16'h02; slave_w[0] = 16'h22;
      hc = 0;
      for (int j = 0; j < 20 && cs_n_v[0]; j++) begin
         hc++;
         @(negedge clk);
      end
      chk("held_cs_gap", 0, hc, 5);
      wait_done(0, 200, t2);
      chk("held_spacing12", 0, t2 - t1, 95);
      chk("held_dout2", 0, dout_v[0], 16'h22);
      din_v[0] = 16'h03; slave_w[0] = 16'h33;
      wait_done(0, 200, t3);
      start_v[0] = 1'b0;
      chk("held_spacing23", 0, t3 - t2, 95);
      chk("held_dout3", 0, dout_v[0], 16'h33);
      repeat (10) @(negedge clk);

      // reset on sclk edge 7
      din_v[0] = 16'h5A; slave_w[0] = 16'h96; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (39) @(negedge clk);
      chk("pre_rst_busy", 0, busy_v[0], 1);
      rst_v[0] = 1'b1;
      @(negedge clk);
      rst_v[0] = 1'b0;
      chk("rst_cs_n", 0, cs_n_v[0], 1);
      chk("rst_sclk", 0, sclk_v[0], 1);
      chk("rst_busy", 0, busy_v[0], 0);
      chk("rst_done", 0, done_v[0], 0);
      chk("rst_data_out", 0, dout_v[0], 0);
      nd = 0;
      repeat (100) begin
         @(negedge clk);
         if (done_v[0]) nd++;
      end
      chk("rst_no_done", 0, nd, 0);
      run_frame(0, 16'hFF, 16'hC3, 120, 0, -1, lat, csl, edg, nd, dcap, pm, ps);
      chk("post_rst_latency", 0, lat, 91);
      chk("post_rst_data_out", 0, dcap, 16'hC3);

      // mode 0 loopback
      run_frame(1, 16'h81, 16'h7E, 120, 10, -1, lat, csl, edg, nd, dcap, pm, ps);
      chk("m0_latency", 1, lat, 91);
      chk("m0_edges", 1, edg, 16);
      chk("m0_data_out", 1, dcap, 16'h7E);
      chk("m0_mosi_pre_edge", 1, pm, 1);
      chk("m0_sclk_idle", 1, ps, 0);

      // 16-bit word, HALF=2
      run_frame(2, 16'hBEEF, 16'h1234, 90, 0, -1, lat, csl, edg, nd, dcap, pm, ps);
      chk("w16_latency", 2, lat, 69);
      chk("w16_cs_low", 2, csl, 68);
      chk("w16_edges", 2, edg, 32);
      chk("w16_ndone", 2, nd, 1);
      chk("w16_data_out", 2, dcap, 16'h1234);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
